lsu_bus_adapter: RTL and testbench
==================================

LSU_BUS_ADAPTER -- requirements
Module: lsu_bus_adapter

Interface
REQ-001 Parameter XLEN, default 32, data and address width; legal values 32 and 64.
REQ-002 Parameter TIMEOUT, default 16, the maximum cycles from bus request to completion before abort; legal range 2..255.
REQ-003 clk  in  1  Single clock; all state updates on the rising edge.
REQ-004 rst  in  1  Synchronous, active-high reset.
REQ-005 req_valid_i  in  1  Core access request.
REQ-006 req_ready_o  out  1  Adapter accepts a request; high only in IDLE.
REQ-007 req_we_i  in  1  1 = store, 0 = load.
REQ-008 req_size_i  in  2  Access size: 00 byte, 01 half, 10 word, 11 dword; 11 is legal only when XLEN=64.
REQ-009 req_unsigned_i  in  1  Zero-extend load data (lbu/lhu/lwu).
REQ-010 req_addr_i  in  XLEN  Byte address.
REQ-011 req_wdata_i  in  XLEN  Store data, right-aligned.
REQ-012 rsp_valid_o  out  1  One-cycle completion pulse.
REQ-013 rsp_rdata_o  out  XLEN  Extended load data; 0 for stores and errors.
REQ-014 rsp_err_o  out  2  Error code: bit0 misaligned or illegal size, bit1 timeout.
REQ-015 mem_valid_o  out  1  Bus request.
REQ-016 mem_ready_i  in  1  Bus accepts the request.
REQ-017 mem_we_o  out  1  Bus write.
REQ-018 mem_addr_o  out  XLEN  Bus address, aligned to XLEN/8 (low bits zero).
REQ-019 mem_wstrb_o  out  XLEN/8  Byte-lane write strobes.
REQ-020 mem_wdata_o  out  XLEN  Store data shifted into its byte lanes.
REQ-021 mem_rvalid_i  in  1  Read data valid.
REQ-022 mem_rdata_i  in  XLEN  Full-width read data.

Function
REQ-023 The state machine SHALL have four states (IDLE, REQ, WAIT, RSP) and SHALL accept a request in IDLE when req_valid_i & req_ready_o.
REQ-024 On acceptance the adapter SHALL register the address, size, sign mode and lane-shifted data; core inputs are not sampled again until the next IDLE.
REQ-025 If the address is misaligned to the access size, or req_size_i=11 with XLEN=32, the adapter SHALL go IDLE->RSP with rsp_err_o=01 and SHALL NOT assert mem_valid_o.
REQ-026 In REQ, mem_valid_o SHALL be 1 with stable address, strobes and data until mem_ready_i=1.
REQ-027 A store handshake SHALL go REQ->RSP; a load handshake SHALL go REQ->WAIT.
REQ-028 In WAIT, on mem_rvalid_i=1 the adapter SHALL select the addressed lane, sign- or zero-extend it to XLEN, and go WAIT->RSP.
REQ-029 In RSP, rsp_valid_o SHALL be 1 for exactly one cycle, followed by a return to IDLE.
REQ-030 Minimum latency from acceptance to rsp_valid_o: store 2 cycles, load 3 cycles (mem_ready_i and mem_rvalid_i each asserted in the first cycle possible).
REQ-031 A timeout counter SHALL clear on acceptance and increment in REQ and WAIT.
REQ-032 When the counter reaches TIMEOUT, the adapter SHALL drop mem_valid_o, go to RSP with rsp_err_o=10, and set rsp_rdata_o=0.
REQ-033 mem_rvalid_i asserted outside WAIT SHALL be ignored.
REQ-034 mem_ready_i and mem_rvalid_i both high in the REQ cycle of a load SHALL count as the handshake only; the read data SHALL be taken from WAIT.
REQ-035 Write strobes SHALL be: byte 1<<offset, half 3<<offset, word 0xF<<offset, dword all ones.

Reset
REQ-036 While rst=1 the adapter SHALL hold IDLE, with all outputs 0 except req_ready_o=1, and SHALL clear the counter and all captured registers.
REQ-037 Reset asserted mid-transaction SHALL abort it with no rsp_valid_o pulse; mem_valid_o SHALL be 0 from the first reset cycle.

Structure
REQ-038 The size encodings, state enum and error bit positions SHALL live in the shared core package.
REQ-039 Lane select and sign extension SHALL be one combinational sub-module, lsu_load_align.

Verification
REQ-040 XLEN=32, sw x=0x2a to 0x104 with ready at once -> mem_addr 0x104, wstrb 1111, wdata 0000002a; rsp_valid 2 cycles after acceptance, err 00.
REQ-041 sb 0x80 to 0x201 -> mem_addr 0x200, wstrb 0010, wdata 00008000.
REQ-042 lb and lbu at 0x200 with mem_rdata 0x00000080 -> rsp_rdata ffffff80 and 00000080; lh at 0x302 with rdata 0x80010000 -> ffff8001.
REQ-043 lh at 0x301 -> mem_valid_o never asserted, rsp_err 01 one cycle after acceptance; XLEN=64 ld at 0x8 with rdata 0x8000000000000001 -> same value, err 00.
REQ-044 TIMEOUT=4 with mem_ready_i held 0 -> rsp_err 10 after 4 REQ cycles; separately, rst pulsed in WAIT -> no rsp_valid, and the next request completes normally.

Source files
------------

// File: rtl/lsu_bus_adapter_pkg.sv
// Shared definitions for the load/store bus adapter.
//   size_e       : access size encoding as driven on req_size_i
//   state_e      : adapter state machine states
//   ERR_*        : bit positions inside rsp_err_o
//   misaligned() : true when a byte address is not aligned to the access size
package lsu_bus_adapter_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10,
    S_RSP  = 2'b11
  } state_e;

  localparam int ERR_MISALIGN = 0;  // misaligned address or illegal size
  localparam int ERR_TIMEOUT  = 1;  // bus did not complete in time

  function automatic logic misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
    logic bad;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = addr_lo[0];
      SIZE_W:  bad = |addr_lo[1:0];
      default: bad = |addr_lo[2:0];
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-data alignment: picks the addressed lane out of a
// full-width bus word and sign- or zero-extends it to XLEN.
//   rdata       : full-width read data from the bus
//   offset      : byte offset of the access inside the bus word
//   size        : access size (size_e encoding)
//   is_unsigned : 1 = zero-extend, 0 = sign-extend
//   data        : right-aligned, extended result
module lsu_load_align
  import lsu_bus_adapter_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]  rdata,
  input  logic [OFF_W-1:0] offset,
  input  logic [1:0]       size,
  input  logic             is_unsigned,
  output logic [XLEN-1:0]  data
);

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] keep_mask;
  logic            sign;

  // Extension is done with a mask rather than replication so the same code
  // holds for XLEN=32, where a word already fills the whole result.
  // NOTE: every always_comb output gets a value before the case so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    shifted   = rdata >> {offset, 3'b000};
    keep_mask = '1;
    sign      = 1'b0;
    case (size)
      SIZE_B: begin
        keep_mask = XLEN'(8'hFF);
        sign      = shifted[7];
      end
      SIZE_H: begin
        keep_mask = XLEN'(16'hFFFF);
        sign      = shifted[15];
      end
      SIZE_W: begin
        keep_mask = XLEN'(32'hFFFF_FFFF);
        sign      = shifted[31];
      end
      default: begin
        keep_mask = '1;
        sign      = 1'b0;
      end
    endcase
    data = (shifted & keep_mask) | ((sign && !is_unsigned) ? ~keep_mask : '0);
  end

endmodule

// File: rtl/lsu_bus_adapter.sv
// Adapter between a core load/store unit and a simple valid/ready memory bus.
// One access at a time: IDLE accepts, REQ holds the bus request, WAIT
// collects load data, RSP pulses the completion for one cycle.
//   clk, rst              : clock, synchronous active-high reset
//   req_*                 : core request (valid/ready, we, size, unsigned, addr, wdata)
//   rsp_valid_o/rdata/err : one-cycle completion with extended data and error code
//   mem_valid_o..wdata_o  : bus request with aligned address and byte lanes
//   mem_ready_i           : bus accepts the request
//   mem_rvalid_i/rdata_i  : full-width read return
module lsu_bus_adapter
  import lsu_bus_adapter_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [XLEN-1:0]   req_addr_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  output logic              rsp_valid_o,
  output logic [XLEN-1:0]   rsp_rdata_o,
  output logic [1:0]        rsp_err_o,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic              mem_we_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN/8-1:0] mem_wstrb_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  state_e           state;
  logic [7:0]       cnt;
  logic [OFF_W-1:0] off_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic             ready_q;
  logic             mem_valid_q;
  logic             rsp_valid_q;

  logic [OFF_W-1:0] req_off;
  logic             req_bad;
  logic [NB-1:0]    req_strb;
  logic [XLEN-1:0]  req_mask;
  logic [XLEN-1:0]  load_data;

  // Request decode: error check, strobes and lane-shifted store data.
  always_comb begin
    req_off  = req_addr_i[OFF_W-1:0];
    req_bad  = misaligned(req_addr_i[2:0], req_size_i) ||
               (req_size_i == SIZE_D && XLEN == 32);
    req_strb = '1;
    req_mask = '1;
    case (req_size_i)
      SIZE_B: begin
        req_strb = NB'(1) << req_off;
        req_mask = XLEN'(8'hFF);
      end
      SIZE_H: begin
        req_strb = NB'(3) << req_off;
        req_mask = XLEN'(16'hFFFF);
      end
      SIZE_W: begin
        req_strb = NB'(4'hF) << req_off;
        req_mask = XLEN'(32'hFFFF_FFFF);
      end
      default: begin
        req_strb = '1;
        req_mask = '1;
      end
    endcase
  end

  lsu_load_align #(.XLEN(XLEN), .OFF_W(OFF_W)) u_align (
    .rdata       (mem_rdata_i),
    .offset      (off_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .data        (load_data)
  );

  // Reset is synchronous, so the registered valids are masked with rst to
  // drop them in the very first reset cycle, not one edge later.
  assign mem_valid_o = mem_valid_q && !rst;
  assign rsp_valid_o = rsp_valid_q && !rst;
  assign req_ready_o = ready_q || rst;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      off_q       <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      ready_q     <= 1'b1;
      mem_valid_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= '0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wstrb_o <= '0;
      mem_wdata_o <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid_i) begin
            ready_q     <= 1'b0;
            cnt         <= '0;
            off_q       <= req_off;
            size_q      <= req_size_i;
            uns_q       <= req_unsigned_i;
            mem_we_o    <= req_we_i;
            mem_addr_o  <= {req_addr_i[XLEN-1:OFF_W], {OFF_W{1'b0}}};
            mem_wstrb_o <= req_strb;
            mem_wdata_o <= (req_wdata_i & req_mask) << {req_off, 3'b000};
            rsp_rdata_o <= '0;
            rsp_err_o   <= '0;
            if (req_bad) begin
              rsp_err_o[ERR_MISALIGN] <= 1'b1;
              rsp_valid_q             <= 1'b1;
              state                   <= S_RSP;
            end else begin
              mem_valid_q <= 1'b1;
              state       <= S_REQ;
            end
          end
        end
        S_REQ: begin
          // A handshake in the last allowed cycle still wins over timeout.
          if (mem_ready_i) begin
            mem_valid_q <= 1'b0;
            cnt         <= cnt + 8'd1;
            if (mem_we_o) begin
              rsp_valid_q <= 1'b1;
              state       <= S_RSP;
            end else begin
              state <= S_WAIT;
            end
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            mem_valid_q            <= 1'b0;
            rsp_err_o[ERR_TIMEOUT] <= 1'b1;
            rsp_valid_q            <= 1'b1;
            state                  <= S_RSP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_WAIT: begin
          if (mem_rvalid_i) begin
            rsp_rdata_o <= load_data;
            rsp_valid_q <= 1'b1;
            state       <= S_RSP;
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            rsp_err_o[ERR_TIMEOUT] <= 1'b1;
            rsp_valid_q            <= 1'b1;
            state                  <= S_RSP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_adapter.sv
// Directed bench: a 32-bit adapter with a short timeout and a 64-bit adapter
// for the dword path, sharing clock and reset.
module tb_lsu_bus_adapter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // 32-bit instance
  logic        req_valid = 0, req_we = 0, req_unsigned = 0;
  logic [1:0]  req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        req_ready, rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        mem_valid, mem_we;
  logic        mem_ready = 0, mem_rvalid = 0;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 0;
  logic [3:0]  mem_wstrb;

  // 64-bit instance
  logic        q_req_valid = 0;
  logic [1:0]  q_req_size = 0;
  logic [63:0] q_req_addr = 0;
  logic        q_req_ready, q_rsp_valid;
  logic [63:0] q_rsp_rdata;
  logic [1:0]  q_rsp_err;
  logic        q_mem_valid, q_mem_we;
  logic        q_mem_ready = 0, q_mem_rvalid = 0;
  logic [63:0] q_mem_addr, q_mem_wdata;
  logic [63:0] q_mem_rdata = 0;
  logic [7:0]  q_mem_wstrb;

  lsu_bus_adapter #(.XLEN(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_size_i(req_size), .req_unsigned_i(req_unsigned),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wstrb_o(mem_wstrb), .mem_wdata_o(mem_wdata),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );

  lsu_bus_adapter #(.XLEN(64), .TIMEOUT(16)) dut64 (
    .clk(clk), .rst(rst),
    .req_valid_i(q_req_valid), .req_ready_o(q_req_ready), .req_we_i(1'b0),
    .req_size_i(q_req_size), .req_unsigned_i(1'b0),
    .req_addr_i(q_req_addr), .req_wdata_i(64'h0),
    .rsp_valid_o(q_rsp_valid), .rsp_rdata_o(q_rsp_rdata), .rsp_err_o(q_rsp_err),
    .mem_valid_o(q_mem_valid), .mem_ready_i(q_mem_ready), .mem_we_o(q_mem_we),
    .mem_addr_o(q_mem_addr), .mem_wstrb_o(q_mem_wstrb), .mem_wdata_o(q_mem_wdata),
    .mem_rvalid_i(q_mem_rvalid), .mem_rdata_i(q_mem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; returns in the first cycle after acceptance.
  task automatic start(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_mem_valid", 64'(mem_valid), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_err", 64'(rsp_err), 64'd0);
    check("rst_addr_strb", {mem_addr, 28'd0, mem_wstrb}, 64'd0);
    check("rst_wdata_we", {mem_wdata, 31'd0, mem_we}, 64'd0);
    check("rst_rdata", 64'(rsp_rdata), 64'd0);
    rst = 1'b0;
    tick();

    // sw 0x2a -> 0x104, bus ready at once
    start(1'b1, 2'b10, 1'b0, 32'h104, 32'h2a);
    check("sw_ready_low", 64'(req_ready), 64'd0);
    check("sw_mem_valid", 64'(mem_valid), 64'd1);
    check("sw_mem_we", 64'(mem_we), 64'd1);
    check("sw_addr", 64'(mem_addr), 64'h104);
    check("sw_wstrb", 64'(mem_wstrb), 64'hF);
    check("sw_wdata", 64'(mem_wdata), 64'h0000002a);
    check("sw_no_early_rsp", 64'(rsp_valid), 64'd0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("sw_rsp_valid", 64'(rsp_valid), 64'd1);
    check("sw_rsp_err", 64'(rsp_err), 64'd0);
    check("sw_mem_valid_drop", 64'(mem_valid), 64'd0);
    tick();
    check("sw_rsp_one_cycle", 64'(rsp_valid), 64'd0);
    check("sw_back_idle", 64'(req_ready), 64'd1);

    // sb 0x80 -> 0x201
    start(1'b1, 2'b00, 1'b0, 32'h201, 32'h80);
    check("sb_addr", 64'(mem_addr), 64'h200);
    check("sb_wstrb", 64'(mem_wstrb), 64'h2);
    check("sb_wdata", 64'(mem_wdata), 64'h00008000);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("sb_rsp", {62'd0, rsp_valid, rsp_err[0]}, 64'd2);
    tick();

    // lb 0x200; rvalid with junk data in the REQ cycle must be ignored
    start(1'b0, 2'b00, 1'b0, 32'h200, 32'h0);
    check("lb_mem_valid", 64'(mem_valid), 64'd1);
    check("lb_mem_we", 64'(mem_we), 64'd0);
    mem_ready  = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hdeadbeef;
    tick();
    mem_ready = 1'b0;
    mem_rdata = 32'h00000080;
    check("lb_wait_no_rsp", 64'(rsp_valid), 64'd0);
    check("lb_wait_mem_valid", 64'(mem_valid), 64'd0);
    tick();
    mem_rvalid = 1'b0;
    check("lb_rsp_valid", 64'(rsp_valid), 64'd1);
    check("lb_rdata", 64'(rsp_rdata), 64'hffffff80);
    check("lb_err", 64'(rsp_err), 64'd0);
    tick();

    // lbu 0x200
    start(1'b0, 2'b00, 1'b1, 32'h200, 32'h0);
    mem_ready = 1'b1;
    tick();
    mem_ready  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h00000080;
    tick();
    mem_rvalid = 1'b0;
    check("lbu_rdata", 64'(rsp_rdata), 64'h00000080);
    tick();

    // lh 0x302 with rdata 0x80010000
    start(1'b0, 2'b01, 1'b0, 32'h302, 32'h0);
    check("lh_addr", 64'(mem_addr), 64'h300);
    mem_ready = 1'b1;
    tick();
    mem_ready  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h80010000;
    tick();
    mem_rvalid = 1'b0;
    check("lh_rdata", 64'(rsp_rdata), 64'hffff8001);
    tick();

    // rvalid while IDLE produces nothing
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    check("idle_rvalid_ignored", 64'(rsp_valid), 64'd0);

    // lh 0x301 misaligned: straight to RSP, no bus request
    start(1'b0, 2'b01, 1'b0, 32'h301, 32'h0);
    check("mis_mem_valid", 64'(mem_valid), 64'd0);
    check("mis_rsp_valid", 64'(rsp_valid), 64'd1);
    check("mis_err", 64'(rsp_err), 64'd1);
    check("mis_rdata", 64'(rsp_rdata), 64'd0);
    tick();
    check("mis_mem_valid_after", 64'(mem_valid), 64'd0);

    // dword on XLEN=32 is illegal
    start(1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
    check("d32_err", {62'd0, rsp_valid, mem_valid, rsp_err}, {60'd0, 4'b1001});
    tick();

    // Timeout with bus never ready: 4 REQ cycles then err 10
    start(1'b1, 2'b10, 1'b0, 32'h10, 32'h1);
    check("to_req1", 64'(mem_valid), 64'd1);
    tick();
    tick();
    tick();
    check("to_req4", {62'd0, mem_valid, rsp_valid}, 64'd2);
    tick();
    check("to_rsp_valid", 64'(rsp_valid), 64'd1);
    check("to_err", 64'(rsp_err), 64'd2);
    check("to_mem_valid", 64'(mem_valid), 64'd0);
    check("to_rdata", 64'(rsp_rdata), 64'd0);
    tick();

    // Reset during REQ: mem_valid low in the first reset cycle
    start(1'b1, 2'b10, 1'b0, 32'h20, 32'h5);
    check("rreq_mem_valid", 64'(mem_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("rreq_mem_valid_rst", 64'(mem_valid), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    check("rreq_idle", {62'd0, req_ready, mem_valid}, 64'd2);

    // Reset during WAIT: no response, next load is normal
    start(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    rst       = 1'b1;
    tick();
    rst        = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h55;
    check("rwait_no_rsp0", 64'(rsp_valid), 64'd0);
    tick();
    mem_rvalid = 1'b0;
    check("rwait_no_rsp1", 64'(rsp_valid), 64'd0);
    check("rwait_ready", 64'(req_ready), 64'd1);
    start(1'b0, 2'b10, 1'b0, 32'h404, 32'h0);
    check("after_rst_addr", 64'(mem_addr), 64'h404);
    mem_ready = 1'b1;
    tick();
    mem_ready  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h12345678;
    tick();
    mem_rvalid = 1'b0;
    check("after_rst_rsp", {62'd0, rsp_valid, rsp_err[1]}, 64'd2);
    check("after_rst_rdata", 64'(rsp_rdata), 64'h12345678);
    tick();

    // XLEN=64: ld 0x8
    q_req_valid = 1'b1;
    q_req_size  = 2'b11;
    q_req_addr  = 64'h8;
    tick();
    q_req_valid = 1'b0;
    check("ld64_addr", q_mem_addr, 64'h8);
    check("ld64_mem_valid", 64'(q_mem_valid), 64'd1);
    q_mem_ready = 1'b1;
    tick();
    q_mem_ready  = 1'b0;
    q_mem_rvalid = 1'b1;
    q_mem_rdata  = 64'h8000000000000001;
    tick();
    q_mem_rvalid = 1'b0;
    check("ld64_rsp_valid", 64'(q_rsp_valid), 64'd1);
    check("ld64_rdata", q_rsp_rdata, 64'h8000000000000001);
    check("ld64_err", 64'(q_rsp_err), 64'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
